// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                      |
// | Description : Shared widths, reset PC and fetch state encoding for the CPU.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int          DEF_ADDR_W   = 8;
  localparam int          DEF_INSTR_W  = 16;
  localparam int          DEF_CNT_W    = 16;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DELIVER = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_next                                                      |
// | Description : Next-PC select: sequential increment or branch target.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pc_next
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              PCsrc,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] w_pc_inc;

  // Increment wraps naturally at the address width.
  assign w_pc_inc = pc + ADDR_W'(1);
  assign next_pc  = PCsrc ? branch_target : w_pc_inc;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_fetch                                            |
// | Description : Fetch stage: PC, imem req/ack, valid/ready handoff to decode.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          INSTR_W  = DEF_INSTR_W,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int          CNT_W    = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               PCsrc,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_sel;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_out;
  logic [CNT_W-1:0]   r_fetch_count;
  logic               w_ack;
  logic               w_handoff;

  pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc            (r_pc),
    .PCsrc         (PCsrc),
    .branch_target (branch_target),
    .next_pc       (w_pc_sel)
  );

  // The request is only live once imem_req has actually been driven high,
  // so an ack in the first cycle after reset release is not taken.
  always_comb begin
    w_ack       = 1'b0;
    w_handoff   = 1'b0;
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      FETCH: begin
        w_ack = r_imem_req && imem_ack;
        if (w_ack) w_state_nxt = DELIVER;
      end
      DELIVER: begin
        w_handoff = instr_ready;
        if (w_handoff) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = w_pc_sel;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= FETCH;
      r_pc          <= c_reset_pc;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_pc_out      <= c_reset_pc;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_imem_req    <= (w_state_nxt == FETCH);
      r_instr_valid <= (w_state_nxt == DELIVER);
      if (w_ack) begin
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
      end
      if (w_handoff && (r_fetch_count != c_cnt_max)) begin
        r_fetch_count <= r_fetch_count + CNT_W'(1);
      end
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc_out      = r_pc_out;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instruction_fetch                                         |
// | Description : Directed bench with a transaction-level model of the fetch.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, instr_valid, instr_ready, PCsrc;
  logic [7:0]  imem_addr, branch_target, pc_out;
  logic [15:0] imem_rdata, instr, fetch_count;

  logic        b_req, b_ack, b_valid;
  logic [7:0]  b_addr, b_pc_out;
  logic [15:0] b_rdata, b_instr;
  logic [3:0]  b_count;
  logic        b_en;

  logic        mem_en, force_ack, cmp_en;
  logic [15:0] force_data;
  int          lat;
  int          wcnt;
  int          checks   = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  instruction_fetch dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .PCsrc(PCsrc),
    .branch_target(branch_target), .pc_out(pc_out), .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hFF), .CNT_W(4)) dut_b (
    .clock(clock), .reset(reset), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata), .instr(b_instr),
    .instr_valid(b_valid), .instr_ready(1'b1), .PCsrc(1'b0),
    .branch_target(8'h00), .pc_out(b_pc_out), .fetch_count(b_count)
  );

  // Memory: word at address a is 0x1001+a, ack after `lat` waiting cycles.
  assign imem_ack   = force_ack | (mem_en & imem_req & (wcnt >= lat));
  assign imem_rdata = force_ack ? force_data : (16'h1001 + {8'h00, imem_addr});
  assign b_ack      = b_en & b_req;
  assign b_rdata    = 16'hB000 + {8'h00, b_addr};

  always @(posedge clock) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  // Transaction model: a request is outstanding once armed, a word is held
  // until the consumer takes it, then the PC moves on.
  logic        m_armed, m_holding;
  logic [7:0]  m_pc, m_pc_out;
  logic [15:0] m_instr, m_cnt;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_armed = 1'b0; m_holding = 1'b0; m_pc = 8'h00;
      m_pc_out = 8'h00; m_instr = 16'h0000; m_cnt = 16'h0000;
    end else if (!m_holding) begin
      if (m_armed && imem_ack) begin
        m_instr   = imem_rdata;
        m_pc_out  = m_pc;
        m_holding = 1'b1;
      end
      m_armed = 1'b1;
    end else if (instr_ready) begin
      m_pc = PCsrc ? branch_target : m_pc + 8'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_holding = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("model_req",   {31'd0, imem_req},    {31'd0, m_armed && !m_holding});
      chk("model_valid", {31'd0, instr_valid}, {31'd0, m_holding});
      chk("model_instr", {16'd0, instr},       {16'd0, m_instr});
      chk("model_pcout", {24'd0, pc_out},      {24'd0, m_pc_out});
      chk("model_count", {16'd0, fetch_count}, {16'd0, m_cnt});
      if (m_armed && !m_holding) chk("model_addr", {24'd0, imem_addr}, {24'd0, m_pc});
    end
  end

  int k;

  initial begin
    reset = 1'b1; mem_en = 1'b0; force_ack = 1'b0; force_data = 16'h0;
    instr_ready = 1'b0; PCsrc = 1'b0; branch_target = 8'h00; lat = 0;
    b_en = 1'b0; cmp_en = 1'b0; wcnt = 0;
    #1 reset = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset held for 5 cycles
    repeat (5) begin
      @(negedge clock);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {24'd0, imem_addr}, 32'h00);

    // Zero-wait memory, consumer always ready
    mem_en = 1'b1; instr_ready = 1'b1; k = 0;
    repeat (8) begin
      @(negedge clock);
      if (instr_valid) begin
        chk("seq_instr", {16'd0, instr}, 32'h1001 + k);
        chk("seq_pcout", {24'd0, pc_out}, k);
        k++;
      end
    end
    chk("seq_words", k, 4);
    chk("count_after_8", {16'd0, fetch_count}, 32'd4);

    // Backpressure with a non-handoff PCsrc pulse and a spurious ack
    instr_ready = 1'b0;
    @(negedge clock);
    chk("bp_instr0", {16'd0, instr}, 32'h1005);
    PCsrc = 1'b1; branch_target = 8'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      PCsrc = 1'b0;
      force_ack = (i == 1); force_data = 16'hDEAD;
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_req", {31'd0, imem_req}, 32'd0);
      chk("bp_instr", {16'd0, instr}, 32'h1005);
      chk("bp_pcout", {24'd0, pc_out}, 32'h04);
    end
    force_ack = 1'b0;
    instr_ready = 1'b1;
    @(negedge clock);
    chk("bp_next_addr", {24'd0, imem_addr}, 32'h05);
    instr_ready = 1'b0;

    // Taken branch at handoff of the word at 0x05
    @(negedge clock);
    chk("br_pcout", {24'd0, pc_out}, 32'h05);
    PCsrc = 1'b1; branch_target = 8'h40; instr_ready = 1'b1;
    @(negedge clock);
    chk("br_addr", {24'd0, imem_addr}, 32'h40);
    chk("br_req", {31'd0, imem_req}, 32'd1);
    PCsrc = 1'b0; instr_ready = 1'b0;
    @(negedge clock);
    chk("br_instr", {16'd0, instr}, 32'h1041);
    PCsrc = 1'b1; branch_target = 8'h80;
    @(negedge clock);
    PCsrc = 1'b0; instr_ready = 1'b1;
    @(negedge clock);
    chk("pulse_ignored_addr", {24'd0, imem_addr}, 32'h41);
    instr_ready = 1'b0; lat = 3;

    // Async reset while waiting on a slow memory
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_addr", {24'd0, imem_addr}, 32'h00);
    force_ack = 1'b1; force_data = 16'hBAD0;
    repeat (3) @(negedge clock);
    force_ack = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", {24'd0, imem_addr}, 32'h00);
    chk("restart_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      @(negedge clock);
    end
    chk("restart_valid_seen", {31'd0, instr_valid}, 32'd1);
    chk("restart_instr", {16'd0, instr}, 32'h1001);
    chk("restart_pcout", {24'd0, pc_out}, 32'h00);

    // Second instance: wrap from 0xFF and counter saturation at CNT_W=4
    chk("wrap_start_addr", {24'd0, b_addr}, 32'hFF);
    chk("wrap_start_req", {31'd0, b_req}, 32'd1);
    b_en = 1'b1;
    repeat (2) @(negedge clock);
    chk("wrap_addr", {24'd0, b_addr}, 32'h00);
    chk("wrap_count1", {28'd0, b_count}, 32'd1);
    repeat (40) @(negedge clock);
    chk("sat_count", {28'd0, b_count}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
